// File: rtl/alarm_pkg.sv
// Shared definitions for the multi-zone alarm controller: FSM state encoding
// and supported parameter ranges.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_NORMAL  = 2'd1,
    ST_PREVENT = 2'd2,
    ST_ALARM   = 2'd3
  } state_t;

  localparam int NZ_MIN  = 1;
  localparam int NZ_MAX  = 16;
  localparam int DEB_MIN = 1;
  localparam int DEB_MAX = 15;

endpackage

// File: rtl/alarm_debounce.sv
// Saturating debounce counter: q asserts once DEB_CYC consecutive enabled
// samples have seen 'in' high; any low sample restarts the count.
module alarm_debounce #(
  parameter int DEB_CYC = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic in,
  output logic q
);

  localparam int W = $clog2(DEB_CYC + 1);
  localparam logic [W-1:0] MAX = W'(DEB_CYC);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (en) begin
      if (!in)             cnt <= '0;
      else if (cnt != MAX) cnt <= cnt + W'(1);
    end
  end

  assign q = (cnt == MAX);

endmodule

// File: rtl/alarm_zone_ctrl.sv
// Multi-zone alarm controller: round-robin zone scan with per-zone debounce,
// Moore FSM and actuator decode. Optional ALARM_EVT_CNT_EN adds an alarm-entry counter.
module alarm_zone_ctrl
  import alarm_pkg::*;
#(
  parameter int NZ      = 4,
  parameter int DEB_CYC = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NZ-1:0] humoa,
  input  logic [NZ-1:0] humom,
  input  logic [NZ-1:0] glp,
  input  logic          fe,
  input  logic          apagsis,
  input  logic          ack,
  output logic          ledtb,
  output logic          ledprv,
  output logic [NZ-1:0] ext1,
  output logic          boc1,
  output logic          boc2,
  output logic          int_fe,
  output logic [1:0]    state,
  output logic [7:0]    evt_cnt
);

  localparam int PW = (NZ > 1) ? $clog2(NZ) : 1;

  logic [PW-1:0] ptr;
  logic [NZ-1:0] sev_q, prv_q, alm_mask;
  logic          fe_q, any_sev, warn;
  state_t        cur, nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       ptr <= '0;
    else if (apagsis)                ptr <= '0;
    else if (ptr == PW'(NZ - 1))     ptr <= '0;
    else                             ptr <= ptr + PW'(1);
  end

  for (genvar z = 0; z < NZ; z++) begin : g_zone
    logic en;
    assign en = (ptr == PW'(z));

    alarm_debounce #(.DEB_CYC(DEB_CYC)) u_sev (
      .clk(clk), .reset(reset), .clr(apagsis), .en(en),
      .in(humoa[z] | (humom[z] & glp[z])), .q(sev_q[z])
    );
    alarm_debounce #(.DEB_CYC(DEB_CYC)) u_prv (
      .clk(clk), .reset(reset), .clr(apagsis), .en(en),
      .in(humom[z] | glp[z]), .q(prv_q[z])
    );
  end

  // Power-fail is global, so it is sampled every cycle rather than scanned.
  alarm_debounce #(.DEB_CYC(DEB_CYC)) u_fe (
    .clk(clk), .reset(reset), .clr(apagsis), .en(1'b1), .in(fe), .q(fe_q)
  );

  assign any_sev = |sev_q;
  assign warn    = (|prv_q) | fe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= ST_NORMAL;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    if (apagsis) nxt = ST_OFF;
    else begin
      case (cur)
        ST_OFF:     nxt = ST_NORMAL;
        ST_NORMAL:  if (any_sev) nxt = ST_ALARM; else if (warn) nxt = ST_PREVENT;
        ST_PREVENT: if (any_sev) nxt = ST_ALARM; else if (!warn) nxt = ST_NORMAL;
        ST_ALARM:   if (ack && !any_sev) nxt = warn ? ST_PREVENT : ST_NORMAL;
        default:    nxt = ST_NORMAL;
      endcase
    end
  end

  // Zones that fired during this alarm stay flagged until the alarm is left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 alm_mask <= '0;
    else if (nxt != ST_ALARM)  alm_mask <= '0;
    else if (cur != ST_ALARM)  alm_mask <= sev_q;
    else                       alm_mask <= alm_mask | sev_q;
  end

`ifdef ALARM_EVT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      evt_cnt <= 8'h00;
    else if (nxt == ST_ALARM && cur != ST_ALARM && evt_cnt != 8'hFF)
      evt_cnt <= evt_cnt + 8'h01;
  end
`else
  assign evt_cnt = 8'h00;
`endif

  always_comb begin
    ledtb  = 1'b0;
    ledprv = 1'b0;
    ext1   = '0;
    boc1   = 1'b0;
    boc2   = 1'b0;
    int_fe = 1'b0;
    case (cur)
      ST_NORMAL: ledtb = 1'b1;
      ST_PREVENT: begin
        ledprv = 1'b1;
        ext1   = prv_q;
        int_fe = fe_q;
        if (fe_q && (|prv_q)) boc2 = 1'b1;
        else                  boc1 = 1'b1;
      end
      ST_ALARM: begin
        boc2   = 1'b1;
        ext1   = alm_mask | prv_q;
        int_fe = fe_q;
        ledprv = fe_q;
      end
      default: ;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Directed table-driven bench for alarm_zone_ctrl (NZ=4, DEB_CYC=3) plus
// hand-written sequences for exact scan latency and asynchronous reset.
module tb_alarm_zone_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] humoa, humom, glp, ext1;
  logic       fe, apagsis, ack;
  logic       ledtb, ledprv, boc1, boc2, int_fe;
  logic [1:0] state;
  logic [7:0] evt_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  alarm_zone_ctrl #(.NZ(4), .DEB_CYC(3)) dut (
    .clk(clk), .reset(reset), .humoa(humoa), .humom(humom), .glp(glp),
    .fe(fe), .apagsis(apagsis), .ack(ack), .ledtb(ledtb), .ledprv(ledprv),
    .ext1(ext1), .boc1(boc1), .boc2(boc2), .int_fe(int_fe), .state(state),
    .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] hoa, hom, lp;
    logic       fe, apag, ack;
    int         cyc;
    logic [1:0] st;
    logic       tb, prv;
    logic [3:0] ext;
    logic       b1, b2, ife;
    logic [7:0] evt;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  function automatic vec_t mk(logic [3:0] hoa, logic [3:0] hom, logic [3:0] lp,
                              logic f, logic ap, logic ak, int cyc,
                              logic [1:0] st, logic tb, logic prv, logic [3:0] ext,
                              logic b1, logic b2, logic ife, logic [7:0] evt);
    vec_t v;
    v.hoa = hoa; v.hom = hom; v.lp = lp; v.fe = f; v.apag = ap; v.ack = ak;
    v.cyc = cyc; v.st = st; v.tb = tb; v.prv = prv; v.ext = ext;
    v.b1 = b1; v.b2 = b2; v.ife = ife; v.evt = evt;
    return v;
  endfunction

  function automatic logic [10:0] pk(logic [1:0] st, logic tb, logic prv,
                                     logic [3:0] ext, logic b1, logic b2, logic ife);
    return {st, tb, prv, ext, b1, b2, ife};
  endfunction

  function automatic logic [7:0] evt_exp(logic [7:0] e);
`ifdef ALARM_EVT_CNT_EN
    return e;
`else
    return 8'h00 & e;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] outs();
    return pk(state, ledtb, ledprv, ext1, boc1, boc2, int_fe);
  endfunction

  initial begin
    //              hoa      hom      lp       fe ap ak cyc  st tb pv ext     b1 b2 ife evt
    vt[0]  = mk(4'h0,   4'h0,   4'h0,   0, 0, 0, 50, 1, 1, 0, 4'h0,   0, 0, 0, 0);
    vt[1]  = mk(4'h0,   4'h0,   4'b0100,0, 0, 0, 13, 2, 0, 1, 4'b0100,1, 0, 0, 0);
    vt[2]  = mk(4'h0,   4'h0,   4'h0,   0, 0, 0, 13, 1, 1, 0, 4'h0,   0, 0, 0, 0);
    vt[3]  = mk(4'h0,   4'h0,   4'b0010,0, 0, 0, 4,  1, 1, 0, 4'h0,   0, 0, 0, 0);
    vt[4]  = mk(4'h0,   4'h0,   4'h0,   0, 0, 0, 13, 1, 1, 0, 4'h0,   0, 0, 0, 0);
    vt[5]  = mk(4'b0001,4'h0,   4'h0,   0, 0, 0, 13, 3, 0, 0, 4'b0001,0, 1, 0, 1);
    vt[6]  = mk(4'h0,   4'h0,   4'h0,   0, 0, 0, 13, 3, 0, 0, 4'b0001,0, 1, 0, 1);
    vt[7]  = mk(4'h0,   4'h0,   4'h0,   0, 0, 1, 1,  1, 1, 0, 4'h0,   0, 0, 0, 1);
    vt[8]  = mk(4'h0,   4'h0,   4'h0,   0, 0, 0, 2,  1, 1, 0, 4'h0,   0, 0, 0, 1);
    vt[9]  = mk(4'b1000,4'h0,   4'h0,   0, 0, 1, 13, 3, 0, 0, 4'b1000,0, 1, 0, 2);
    vt[10] = mk(4'b1000,4'h0,   4'h0,   1, 0, 1, 3,  3, 0, 1, 4'b1000,0, 1, 1, 2);
    vt[11] = mk(4'b1000,4'h0,   4'h0,   1, 1, 1, 1,  0, 0, 0, 4'h0,   0, 0, 0, 2);
    vt[12] = mk(4'b1000,4'h0,   4'h0,   1, 1, 1, 5,  0, 0, 0, 4'h0,   0, 0, 0, 2);
    vt[13] = mk(4'h0,   4'h0,   4'h0,   0, 0, 0, 1,  1, 1, 0, 4'h0,   0, 0, 0, 2);
    vt[14] = mk(4'h0,   4'h0,   4'h0,   0, 0, 0, 10, 1, 1, 0, 4'h0,   0, 0, 0, 2);
    vt[15] = mk(4'h0,   4'h0,   4'h0,   1, 0, 0, 4,  2, 0, 1, 4'h0,   1, 0, 1, 2);
    vt[16] = mk(4'h0,   4'h0,   4'b0001,1, 0, 0, 13, 2, 0, 1, 4'b0001,0, 1, 1, 2);
    vt[17] = mk(4'h0,   4'h0,   4'h0,   0, 0, 0, 13, 1, 1, 0, 4'h0,   0, 0, 0, 2);
    vt[18] = mk(4'h0,   4'b0100,4'b0100,0, 0, 0, 13, 3, 0, 0, 4'b0100,0, 1, 0, 3);
    vt[19] = mk(4'h0,   4'h0,   4'h0,   0, 0, 1, 13, 1, 1, 0, 4'h0,   0, 0, 0, 3);
    vt[20] = mk(4'b0001,4'h0,   4'b0100,0, 0, 0, 13, 3, 0, 0, 4'b0101,0, 1, 0, 4);
    vt[21] = mk(4'h0,   4'h0,   4'b0100,0, 0, 1, 13, 2, 0, 1, 4'b0100,1, 0, 0, 4);
    vt[22] = mk(4'h0,   4'h0,   4'h0,   0, 0, 0, 13, 1, 1, 0, 4'h0,   0, 0, 0, 4);
    vt[23] = mk(4'h0,   4'b0010,4'h0,   0, 0, 0, 13, 2, 0, 1, 4'b0010,1, 0, 0, 4);
    vt[24] = mk(4'h0,   4'h0,   4'h0,   0, 0, 0, 13, 1, 1, 0, 4'h0,   0, 0, 0, 4);

    reset = 1'b1; humoa = '0; humom = '0; glp = '0; fe = 0; apagsis = 0; ack = 0;
    step(3);
    chk("reset_outs", 32'(outs()), 32'(pk(2'd1, 1, 0, 4'h0, 0, 0, 0)));
    chk("reset_evt", 32'(evt_cnt), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      humoa = vt[i].hoa; humom = vt[i].hom; glp = vt[i].lp;
      fe = vt[i].fe; apagsis = vt[i].apag; ack = vt[i].ack;
      step(vt[i].cyc);
      chk($sformatf("vec%0d_outs", i), 32'(outs()),
          32'(pk(vt[i].st, vt[i].tb, vt[i].prv, vt[i].ext, vt[i].b1, vt[i].b2, vt[i].ife)));
      chk($sformatf("vec%0d_evt", i), 32'(evt_cnt), 32'(evt_exp(vt[i].evt)));
    end

    // Shutdown zeroes the scan pointer, so qualify latency from here is exact:
    // zone 0 is sampled on edges 2, 6, 10 after apagsis; state follows one edge later.
    humoa = '0; humom = '0; fe = 0; ack = 0;
    glp = 4'b0001; apagsis = 1;
    step(1);
    chk("lat_off", 32'(outs()), 32'(pk(2'd0, 0, 0, 4'h0, 0, 0, 0)));
    apagsis = 0;
    step(1);
    chk("lat_normal", 32'(state), 32'd1);
    step(8);
    chk("lat_not_yet", 32'(state), 32'd1);
    step(1);
    chk("lat_prevent", 32'(outs()), 32'(pk(2'd2, 0, 1, 4'b0001, 1, 0, 0)));

    // Asynchronous reset out of PREVENT takes effect without a clock edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_outs", 32'(outs()), 32'(pk(2'd1, 1, 0, 4'h0, 0, 0, 0)));
    chk("async_rst_evt", 32'(evt_cnt), 32'h0);
    glp = '0;
    step(2);
    reset = 1'b0;
    step(13);
    chk("post_rst_normal", 32'(outs()), 32'(pk(2'd1, 1, 0, 4'h0, 0, 0, 0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
